// File: rtl/prog_mem_loader_if.sv
// Fetch port and byte-stream load port of the program memory.
// master = fetch stage / host byte source, slave = prog_mem_loader.
interface prog_mem_loader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              fetch_en;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] instruction;
    logic              inst_valid;
    logic              load_start;
    logic [ADDR_W-1:0] load_base;
    logic [ADDR_W:0]   load_len;
    logic [7:0]        load_byte;
    logic              load_valid;
    logic              load_ready;
    logic              busy;
    logic              load_done;
    logic              parity_err;

    modport master (
        output fetch_en, fetch_addr, load_start, load_base, load_len, load_byte, load_valid,
        input  instruction, inst_valid, load_ready, busy, load_done, parity_err
    );

    modport slave (
        input  fetch_en, fetch_addr, load_start, load_base, load_len, load_byte, load_valid,
        output instruction, inst_valid, load_ready, busy, load_done, parity_err
    );
endinterface

// File: rtl/prog_mem_loader.sv
// Program memory with registered fetch and big-endian byte-stream loader.
// Optional per-word even parity enabled by PROG_MEM_PARITY_EN.
//
// state | meaning
// IDLE  | fetches serviced, waiting for load_start
// LOAD  | accepting bytes, assembling and writing words
// DONE  | one-cycle load_done pulse, still busy
module prog_mem_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input logic              clk,
    input logic              rst_n,
    prog_mem_loader_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int BYTES = DATA_W / 8;
    localparam int ASM_W = (DATA_W > 8) ? DATA_W - 8 : 1;
    localparam logic [2:0] LAST_BYTE = 3'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    state_t state_q, state_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   words_left;
    logic [2:0]        byte_cnt;
    logic [ASM_W-1:0]  asm_q;
    logic [DATA_W-1:0] asm_word;
    logic              xfer;
    logic              byte_last;
    logic              word_wr;
    logic              last_word;
    logic              fetch_rd;

    // Word as it would stand once the current byte is shifted in.
    generate
        if (BYTES == 1) begin : g_single
            assign asm_word = bus.load_byte;
        end else begin : g_multi
            assign asm_word = {asm_q, bus.load_byte};
        end
    endgenerate

    assign xfer      = (state_q == LOAD) && bus.load_valid;
    assign byte_last = (byte_cnt == LAST_BYTE);
    assign word_wr   = xfer && byte_last;
    assign last_word = (words_left == (ADDR_W + 1)'(1));
    assign fetch_rd  = (state_q == IDLE) && bus.fetch_en;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.load_start)
                    state_d = (bus.load_len == '0) ? DONE : LOAD;
            end
            LOAD: begin
                if (word_wr && last_word) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = 1'b0;
        bus.load_ready = 1'b0;
        bus.load_done  = 1'b0;
        case (state_q)
            LOAD: begin
                bus.busy       = 1'b1;
                bus.load_ready = 1'b1;
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.load_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.instruction <= '0;
            bus.inst_valid  <= 1'b0;
            wr_ptr          <= '0;
            words_left      <= '0;
            byte_cnt        <= '0;
            asm_q           <= '0;
        end else begin
            bus.inst_valid <= fetch_rd;
            if (fetch_rd) bus.instruction <= mem[bus.fetch_addr];

            if (state_q == IDLE && bus.load_start) begin
                wr_ptr     <= bus.load_base;
                words_left <= bus.load_len;
                byte_cnt   <= '0;
            end else if (xfer) begin
                if (byte_last) begin
                    wr_ptr     <= wr_ptr + 1'b1;
                    words_left <= words_left - 1'b1;
                    byte_cnt   <= '0;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                    asm_q    <= asm_word[ASM_W-1:0];
                end
            end
        end
    end

    // Memory is deliberately outside reset; a write racing reset is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && word_wr) mem[wr_ptr] <= asm_word;
    end

`ifdef PROG_MEM_PARITY_EN
    logic mem_par [DEPTH];

    always_ff @(posedge clk) begin
        if (rst_n && word_wr) mem_par[wr_ptr] <= ^asm_word;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)        bus.parity_err <= 1'b0;
        else if (fetch_rd) bus.parity_err <= (^mem[bus.fetch_addr]) ^ mem_par[bus.fetch_addr];
        else               bus.parity_err <= 1'b0;
    end
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed plus randomized bench for prog_mem_loader against a word-array model.
module tb_prog_mem_loader;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int BYTES  = DATA_W / 8;

    logic clk;
    logic rst_n;

    prog_mem_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    prog_mem_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [7:0]        byte_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_inst_valid"}, 32'(bus.inst_valid), 0);
        check({tag, "_load_ready"}, 32'(bus.load_ready), 0);
        check({tag, "_busy"},       32'(bus.busy), 0);
        check({tag, "_load_done"},  32'(bus.load_done), 0);
        check({tag, "_parity_err"}, 32'(bus.parity_err), 0);
        check({tag, "_instruction"}, 32'(bus.instruction), 0);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            step();
            check_reset_outputs("reset");
        end
        rst_n = 1'b1;
    endtask

    // Fetch one word, then confirm it holds with fetch_en low.
    task automatic fetch_check(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp);
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = addr;
        step();
        check("fetch_valid",  32'(bus.inst_valid), 1);
        check("fetch_data",   32'(bus.instruction), 32'(exp));
        check("fetch_parity", 32'(bus.parity_err), 0);
        bus.fetch_en   = 1'b0;
        bus.fetch_addr = 4'($urandom_range(0, DEPTH - 1));
        step();
        check("hold_valid", 32'(bus.inst_valid), 0);
        check("hold_data",  32'(bus.instruction), 32'(exp));
    endtask

    task automatic fill_bytes(input int n);
        byte_q.delete();
        for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom));
    endtask

    task automatic model_commit(input logic [ADDR_W-1:0] base, input int words);
        for (int w = 0; w < words; w++) begin
            logic [DATA_W-1:0] word = '0;
            for (int b = 0; b < BYTES; b++) word = (word << 8) | DATA_W'(byte_q[w * BYTES + b]);
            ref_mem[(int'(base) + w) % DEPTH] = word;
        end
    endtask

    task automatic run_load(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len,
                            input int gap_max, input bit fetch_during);
        int nb;
        logic [ADDR_W-1:0] fa;
        logic [DATA_W-1:0] fexp;
        nb   = int'(len) * BYTES;
        fa   = 4'($urandom_range(0, DEPTH - 1));
        fexp = ref_mem[fa];
        bus.load_start = 1'b1;
        bus.load_base  = base;
        bus.load_len   = len;
        bus.fetch_en   = fetch_during;
        bus.fetch_addr = fa;
        step();
        bus.load_start = 1'b0;
        if (fetch_during) begin
            check("start_fetch_valid", 32'(bus.inst_valid), 1);
            check("start_fetch_data",  32'(bus.instruction), 32'(fexp));
        end
        check("start_busy", 32'(bus.busy), 1);
        if (len == 0) begin
            check("len0_done",  32'(bus.load_done), 1);
            check("len0_ready", 32'(bus.load_ready), 0);
            bus.fetch_en = 1'b0;
            step();
            check("len0_done_end", 32'(bus.load_done), 0);
            check("len0_busy_end", 32'(bus.busy), 0);
            return;
        end
        check("start_ready", 32'(bus.load_ready), 1);
        check("start_done",  32'(bus.load_done), 0);
        for (int i = 0; i < nb; i++) begin
            int gaps = int'($urandom_range(0, gap_max));
            for (int g = 0; g < gaps; g++) begin
                bus.load_valid = 1'b0;
                bus.load_byte  = 8'($urandom);
                bus.load_start = 1'($urandom);
                bus.load_base  = 4'($urandom);
                bus.load_len   = 5'($urandom_range(0, DEPTH));
                if (fetch_during) bus.fetch_addr = 4'($urandom);
                step();
                check("gap_busy",  32'(bus.busy), 1);
                check("gap_ready", 32'(bus.load_ready), 1);
                check("gap_done",  32'(bus.load_done), 0);
                if (fetch_during) check("gap_inst_valid", 32'(bus.inst_valid), 0);
            end
            bus.load_valid = 1'b1;
            bus.load_byte  = byte_q[i];
            bus.load_start = 1'($urandom);
            step();
            if (i == nb - 1) begin
                check("last_done",  32'(bus.load_done), 1);
                check("last_ready", 32'(bus.load_ready), 0);
                check("last_busy",  32'(bus.busy), 1);
            end else begin
                check("byte_done",  32'(bus.load_done), 0);
                check("byte_ready", 32'(bus.load_ready), 1);
            end
            if (fetch_during) check("load_inst_valid", 32'(bus.inst_valid), 0);
        end
        bus.load_valid = 1'b0;
        bus.load_start = 1'b0;
        bus.fetch_en   = 1'b0;
        step();
        check("end_done",       32'(bus.load_done), 0);
        check("end_busy",       32'(bus.busy), 0);
        check("end_inst_valid", 32'(bus.inst_valid), 0);
        model_commit(base, int'(len));
    endtask

    task automatic fetch_all();
        for (int a = 0; a < DEPTH; a++) fetch_check(4'(a), ref_mem[a]);
    endtask

    initial begin
        logic [ADDR_W-1:0] b;
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
        rst_n          = 1'b0;
        bus.fetch_en   = 1'b0;
        bus.fetch_addr = '0;
        bus.load_start = 1'b0;
        bus.load_base  = '0;
        bus.load_len   = '0;
        bus.load_byte  = '0;
        bus.load_valid = 1'b0;

        do_reset(4);
        fetch_check(4'd5, 16'h0000);

        byte_q = '{8'hA6, 8'h01, 8'hB4, 8'h01, 8'h36, 8'h81};
        run_load(4'd0, 5'd3, 0, 1'b0);
        fetch_check(4'd0, 16'hA601);
        fetch_check(4'd1, 16'hB401);
        fetch_check(4'd2, 16'h3681);

        // instruction is non-zero now, so reset must visibly clear it
        do_reset(4);
        fetch_check(4'd1, ref_mem[1]);

        byte_q = '{8'h12, 8'h34, 8'h56, 8'h78};
        run_load(4'd15, 5'd2, 0, 1'b0);
        fetch_check(4'd15, 16'h1234);
        fetch_check(4'd0,  16'h5678);
        fetch_check(4'd1,  ref_mem[1]);

        fill_bytes(3 * BYTES);
        run_load(4'd4, 5'd3, 3, 1'b1);
        for (int a = 3; a < 8; a++) fetch_check(4'(a), ref_mem[a]);

        // Reset after three bytes of a two-word load.
        b = 4'($urandom_range(0, DEPTH - 1));
        fill_bytes(2 * BYTES);
        bus.load_start = 1'b1;
        bus.load_base  = b;
        bus.load_len   = 5'd2;
        step();
        bus.load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.load_valid = 1'b1;
            bus.load_byte  = byte_q[i];
            step();
        end
        bus.load_valid = 1'b0;
        rst_n = 1'b0;
        step();
        check("midrst_busy",  32'(bus.busy), 0);
        check("midrst_ready", 32'(bus.load_ready), 0);
        check("midrst_done",  32'(bus.load_done), 0);
        rst_n = 1'b1;
        step();
        check("midrst_done_after", 32'(bus.load_done), 0);
        check("midrst_busy_after", 32'(bus.busy), 0);
        model_commit(b, 1);
        fetch_check(b, ref_mem[b]);
        fetch_check(b + 4'd1, ref_mem[b + 4'd1]);

        run_load(4'd9, 5'd0, 0, 1'b1);
        fetch_all();

        for (int it = 0; it < 8; it++) begin
            logic [ADDR_W:0] len = 5'($urandom_range(0, DEPTH));
            fill_bytes(int'(len) * BYTES);
            run_load(4'($urandom), len, 2, 1'($urandom));
            for (int k = 0; k < 4; k++) begin
                logic [ADDR_W-1:0] fa = 4'($urandom);
                fetch_check(fa, ref_mem[fa]);
            end
        end

        fill_bytes(DEPTH * BYTES);
        run_load(4'($urandom), 5'(DEPTH), 1, 1'b1);
        fetch_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
